// File: rtl/pifo_dequeue_shaper_if.sv
// PIFO-head / output-stream bundle of pifo_dequeue_shaper; slave = shaper, master = its environment.
// Pure wiring, no latency and no state; flow control is the valid/ready pair carried here.
interface pifo_dequeue_shaper_if #(
    parameter int PRIORITY_WIDTH = 8,
    parameter int DATA_WIDTH     = 16,
    parameter int TOKEN_WIDTH    = 8
);
    logic                      i__pifo_empty;
    logic [PRIORITY_WIDTH-1:0] i__pifo_priority;
    logic [DATA_WIDTH-1:0]     i__pifo_data;
    logic                      o__pifo_dequeue;
    logic [TOKEN_WIDTH-1:0]    i__refill_tokens;
    logic                      o__data_out_valid;
    logic [PRIORITY_WIDTH-1:0] o__data_out_priority;
    logic [DATA_WIDTH-1:0]     o__data_out;
    logic                      i__data_out_ready;
    logic [TOKEN_WIDTH-1:0]    o__tokens;

    modport slave (
        input  i__pifo_empty, i__pifo_priority, i__pifo_data, i__refill_tokens, i__data_out_ready,
        output o__pifo_dequeue, o__data_out_valid, o__data_out_priority, o__data_out, o__tokens
    );

    modport master (
        output i__pifo_empty, i__pifo_priority, i__pifo_data, i__refill_tokens, i__data_out_ready,
        input  o__pifo_dequeue, o__data_out_valid, o__data_out_priority, o__data_out, o__tokens
    );
endinterface

// File: rtl/pifo_dequeue_shaper.sv
// Token-bucket shaped PIFO dequeue into a 2-entry output buffer; PIFO_DEQUEUE_SHAPER_EN enables the bucket.
// Latency: a popped head is visible on the output one cycle after its dequeue cycle.
// Backpressure: ready only drains the buffer; dequeue stops when it is full, never combinationally from ready.
module pifo_dequeue_shaper #(
    parameter int PRIORITY_WIDTH = 8,
    parameter int DATA_WIDTH     = 16,
    parameter int TOKEN_WIDTH    = 8,
    parameter int BUCKET_MAX     = 16,
    parameter int REFILL_PERIOD  = 4
) (
    input logic                  clk,
    input logic                  reset,
    pifo_dequeue_shaper_if.slave bus
);

    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_e;

    state_e                    state_q;
    logic                      valid_q;
    logic [PRIORITY_WIDTH-1:0] head_prio_q, tail_prio_q;
    logic [DATA_WIDTH-1:0]     head_dat_q, tail_dat_q;

    logic tok_ok;
    logic deq;
    logic xfer;

    // Gated by reset so nothing is popped while the block is held in reset.
    assign deq  = reset & ~bus.i__pifo_empty & tok_ok & (state_q != S_TWO);
    assign xfer = valid_q & bus.i__data_out_ready;

    // Reset drops buffered entries; heads already popped from the PIFO are lost by design.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_EMPTY;
            valid_q     <= 1'b0;
            head_prio_q <= '0;
            head_dat_q  <= '0;
            tail_prio_q <= '0;
            tail_dat_q  <= '0;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (deq) begin
                        head_prio_q <= bus.i__pifo_priority;
                        head_dat_q  <= bus.i__pifo_data;
                        state_q     <= S_ONE;
                        valid_q     <= 1'b1;
                    end
                end
                S_ONE: begin
                    if (deq && !xfer) begin
                        tail_prio_q <= bus.i__pifo_priority;
                        tail_dat_q  <= bus.i__pifo_data;
                        state_q     <= S_TWO;
                    end else if (deq && xfer) begin
                        head_prio_q <= bus.i__pifo_priority;
                        head_dat_q  <= bus.i__pifo_data;
                    end else if (xfer) begin
                        state_q <= S_EMPTY;
                        valid_q <= 1'b0;
                    end
                end
                S_TWO: begin
                    if (xfer) begin
                        head_prio_q <= tail_prio_q;
                        head_dat_q  <= tail_dat_q;
                        state_q     <= S_ONE;
                    end
                end
                default: begin
                    state_q <= S_EMPTY;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef PIFO_DEQUEUE_SHAPER_EN
    localparam int CW = (REFILL_PERIOD > 1) ? $clog2(REFILL_PERIOD) : 1;
    localparam logic [CW-1:0]          CNT_LAST = CW'(REFILL_PERIOD - 1);
    localparam logic [TOKEN_WIDTH:0]   TOK_MAX  = (TOKEN_WIDTH + 1)'(BUCKET_MAX);

    logic [CW-1:0]          cnt_q, cnt_d;
    logic [TOKEN_WIDTH-1:0] tok_q, tok_d;
    logic [TOKEN_WIDTH:0]   tok_sum;
    logic                   refill_evt;

    assign refill_evt = (cnt_q == CNT_LAST);
    assign tok_ok     = (tok_q != '0);

    // One spare bit keeps refill headroom from wrapping before the saturation compare.
    always_comb begin
        cnt_d   = refill_evt ? '0 : cnt_q + CW'(1);
        tok_sum = {1'b0, tok_q} - {{TOKEN_WIDTH{1'b0}}, deq}
                + (refill_evt ? {1'b0, bus.i__refill_tokens} : '0);
        tok_d   = (tok_sum > TOK_MAX) ? TOK_MAX[TOKEN_WIDTH-1:0] : tok_sum[TOKEN_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            tok_q <= TOK_MAX[TOKEN_WIDTH-1:0];
        end else begin
            cnt_q <= cnt_d;
            tok_q <= tok_d;
        end
    end

    assign bus.o__tokens = tok_q;
`else
    logic unused_refill;

    assign tok_ok        = 1'b1;
    assign unused_refill = ^bus.i__refill_tokens;
    assign bus.o__tokens = '0;
`endif

    assign bus.o__pifo_dequeue      = deq;
    assign bus.o__data_out_valid    = valid_q;
    assign bus.o__data_out_priority = head_prio_q;
    assign bus.o__data_out          = head_dat_q;

endmodule

// File: tb/tb_pifo_dequeue_shaper.sv
// Directed bench for pifo_dequeue_shaper: PIFO model feeds the head, a scoreboard queue checks output order.
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
module tb_pifo_dequeue_shaper;
    localparam int PW = 8;
    localparam int DW = 16;
    localparam int TW = 8;
    localparam int BM = 16;
    localparam int RP = 4;
`ifdef PIFO_DEQUEUE_SHAPER_EN
    localparam logic [31:0] TOK_MASK = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] TOK_MASK = 32'h0;
`endif

    typedef logic [PW+DW-1:0] ent_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    pifo_dequeue_shaper_if #(.PRIORITY_WIDTH(PW), .DATA_WIDTH(DW), .TOKEN_WIDTH(TW)) bus ();

    pifo_dequeue_shaper #(
        .PRIORITY_WIDTH(PW), .DATA_WIDTH(DW), .TOKEN_WIDTH(TW),
        .BUCKET_MAX(BM), .REFILL_PERIOD(RP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    ent_t pifo_q[$];
    ent_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    bit   pop_pending = 1'b0;
    bit   hold_vld    = 1'b0;
    ent_t hold_val    = '0;

    function automatic logic [31:0] tokx(input int v);
        return 32'(v) & TOK_MASK;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_pifo();
        bus.i__pifo_empty = (pifo_q.size() == 0);
        if (pifo_q.size() != 0) {bus.i__pifo_priority, bus.i__pifo_data} = pifo_q[0];
    endtask

    task automatic push(input logic [PW-1:0] p, input logic [DW-1:0] d);
        pifo_q.push_back({p, d});
        exp_q.push_back({p, d});
        drive_pifo();
    endtask

    // Negedge: scoreboard, stability of a stalled output, and latching of the pop decision.
    task automatic to_neg();
        ent_t o;
        @(negedge clk);
        o = {bus.o__data_out_priority, bus.o__data_out};
        if (!reset) hold_vld = 1'b0;
        if (hold_vld) begin
            chk("hold_valid", bus.o__data_out_valid, 1);
            chk("hold_data", o, hold_val);
        end
        if (reset && bus.o__data_out_valid && bus.i__data_out_ready) begin
            chk("sb_expected_pending", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) chk("sb_data", o, exp_q.pop_front());
        end
        hold_vld    = reset && bus.o__data_out_valid && !bus.i__data_out_ready;
        hold_val    = o;
        pop_pending = bus.o__pifo_dequeue;
    endtask

    // Posedge+1: track refill phase and retire the popped PIFO head.
    task automatic to_pos();
        @(posedge clk);
        if (reset) cyc++;
        else cyc = 0;
        #1;
        if (pop_pending) begin
            chk("pop_nonempty", 32'(pifo_q.size() != 0), 1);
            if (pifo_q.size() != 0) void'(pifo_q.pop_front());
            pop_pending = 1'b0;
        end
        drive_pifo();
    endtask

    // Called at posedge+1; returns at negedge.
    task automatic drain(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            to_neg();
            if (exp_q.size() == 0) break;
            to_pos();
        end
        chk(tag, exp_q.size(), 0);
    endtask

    // Called at negedge; returns at posedge+1 of a cycle whose refill phase is k.
    task automatic align(input int k);
        to_pos();
        for (int i = 0; i < RP && (cyc % RP) != k; i++) begin
            to_neg();
            to_pos();
        end
    endtask

    task automatic assert_reset();
        reset    = 1'b0;
        hold_vld = 1'b0;
        while (exp_q.size() > pifo_q.size()) void'(exp_q.pop_front());
    endtask

    initial begin
        bus.i__pifo_empty     = 1'b1;
        bus.i__pifo_priority  = '0;
        bus.i__pifo_data      = '0;
        bus.i__refill_tokens  = '0;
        bus.i__data_out_ready = 1'b0;

        // Reset state with a non-empty PIFO, then three entries with ready high.
        push(8'd5, 16'h11);
        push(8'd2, 16'h22);
        push(8'd9, 16'h33);
        to_neg();
        chk("rst_valid", bus.o__data_out_valid, 0);
        chk("rst_deq", bus.o__pifo_dequeue, 0);
        chk("rst_data", bus.o__data_out, 0);
        chk("rst_prio", bus.o__data_out_priority, 0);
        chk("rst_tokens", bus.o__tokens, tokx(BM));
        to_pos();
        reset = 1'b1;
        bus.i__data_out_ready = 1'b1;
        to_neg();
        chk("s1_deq_c1", bus.o__pifo_dequeue, 1);
        chk("s1_valid_c1", bus.o__data_out_valid, 0);
        to_pos(); to_neg();
        chk("s1_deq_c2", bus.o__pifo_dequeue, 1);
        chk("s1_data_c2", bus.o__data_out, 16'h11);
        chk("s1_prio_c2", bus.o__data_out_priority, 5);
        chk("s1_tok_c2", bus.o__tokens, tokx(15));
        to_pos(); to_neg();
        chk("s1_deq_c3", bus.o__pifo_dequeue, 1);
        chk("s1_data_c3", bus.o__data_out, 16'h22);
        chk("s1_tok_c3", bus.o__tokens, tokx(14));
        to_pos(); to_neg();
        chk("s1_deq_c4", bus.o__pifo_dequeue, 0);
        chk("s1_data_c4", bus.o__data_out, 16'h33);
        chk("s1_tok_c4", bus.o__tokens, tokx(13));
        to_pos(); to_neg();
        chk("s1_valid_c5", bus.o__data_out_valid, 0);

        // Stalled output: buffer fills to two and dequeue stops.
        to_pos();
        bus.i__data_out_ready = 1'b0;
        push(8'd7, 16'h11);
        push(8'd3, 16'h22);
        push(8'd1, 16'h33);
        push(8'd8, 16'h44);
        to_neg();
        chk("s2_deq_a", bus.o__pifo_dequeue, 1);
        to_pos(); to_neg();
        chk("s2_deq_b", bus.o__pifo_dequeue, 1);
        chk("s2_data_b", bus.o__data_out, 16'h11);
        to_pos(); to_neg();
        chk("s2_deq_full", bus.o__pifo_dequeue, 0);
        chk("s2_pifo_left", pifo_q.size(), 2);
        chk("s2_tok", bus.o__tokens, tokx(11));
        for (int i = 0; i < 3; i++) begin
            to_pos(); to_neg();
            chk("s2_deq_hold", bus.o__pifo_dequeue, 0);
            chk("s2_data_hold", bus.o__data_out, 16'h11);
        end
        to_pos();
        bus.i__data_out_ready = 1'b1;
        to_neg();
        chk("s2_deq_ready_path", bus.o__pifo_dequeue, 0);
        to_pos();
        drain("s2_drained", 40);
        chk("s2_pifo_empty", pifo_q.size(), 0);
        chk("s2_tok_end", bus.o__tokens, tokx(9));

`ifdef PIFO_DEQUEUE_SHAPER_EN
        // Drain the bucket to zero, then shape at one token per refill period.
        to_pos();
        for (int i = 0; i < 10; i++) push(8'(i), 16'(16'h100 + i));
        for (int i = 0; i < 20; i++) begin to_neg(); to_pos(); end
        to_neg();
        chk("s3_tok_zero", bus.o__tokens, 0);
        chk("s3_deq_stop", bus.o__pifo_dequeue, 0);
        chk("s3_pifo_left", pifo_q.size(), 1);
        align(1);
        bus.i__refill_tokens = 8'd1;
        for (int i = 0; i < 9; i++) push(8'(i + 20), 16'(16'h200 + i));
        for (int i = 0; i < 40; i++) begin
            to_neg();
            chk("s3_deq_phase", bus.o__pifo_dequeue, 32'((cyc % RP) == 0));
            chk("s3_tok_phase", bus.o__tokens, 32'((cyc % RP) == 0));
            to_pos();
        end
        to_neg();
        chk("s3_pifo_empty", pifo_q.size(), 0);
        to_pos();
        drain("s3_drained", 20);

        // Saturation: tokens 12 on a refill cycle with refill 10, with and without a dequeue.
        to_pos();
        assert_reset();
        bus.i__refill_tokens = 8'd0;
        to_neg(); to_pos();
        reset = 1'b1;
        to_neg();
        for (int n = 5; n >= 4; n--) begin
            align(3);
            bus.i__refill_tokens = 8'd0;
            for (int k = 0; k < n; k++) push(8'(k + 40), 16'(16'h300 + 16 * n + k));
            for (int k = 0; k < 4; k++) begin to_neg(); to_pos(); end
            bus.i__refill_tokens = 8'd10;
            to_neg();
            chk("s4_tok_pre", bus.o__tokens, 12);
            chk("s4_deq_refill", bus.o__pifo_dequeue, 32'(n == 5));
            to_pos(); to_neg();
            chk("s4_tok_sat", bus.o__tokens, 16);
        end
        to_pos();
        bus.i__refill_tokens = 8'd0;
        drain("s4_drained", 20);
`endif

        // Reset while two entries are buffered.
        to_pos();
        bus.i__refill_tokens = 8'd0;
        bus.i__data_out_ready = 1'b1;
        for (int i = 0; i < 7; i++) push(8'(i + 60), 16'(16'h400 + i));
        drain("s5_pre_drained", 40);
        chk("s5_tok_pre", bus.o__tokens, tokx(9));
        to_pos();
        bus.i__data_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(8'(i + 70), 16'(16'h500 + i));
        to_neg(); to_pos(); to_neg(); to_pos(); to_neg();
        chk("s5_deq_full", bus.o__pifo_dequeue, 0);
        chk("s5_valid_full", bus.o__data_out_valid, 1);
        chk("s5_tok_full", bus.o__tokens, tokx(7));
        chk("s5_pifo_left", pifo_q.size(), 2);
        to_pos();
        assert_reset();
        #1;
        chk("s5_async_valid", bus.o__data_out_valid, 0);
        chk("s5_async_deq", bus.o__pifo_dequeue, 0);
        chk("s5_async_data", bus.o__data_out, 0);
        chk("s5_async_prio", bus.o__data_out_priority, 0);
        chk("s5_async_tok", bus.o__tokens, tokx(BM));
        for (int i = 0; i < 2; i++) begin
            to_neg();
            chk("s5_deq_in_reset", bus.o__pifo_dequeue, 0);
            to_pos();
        end
        reset = 1'b1;
        bus.i__data_out_ready = 1'b1;
        to_neg();
        chk("s5_deq_first", bus.o__pifo_dequeue, 1);
        chk("s5_tok_release", bus.o__tokens, tokx(BM));
        to_pos();
        drain("s5_drained", 20);

`ifndef PIFO_DEQUEUE_SHAPER_EN
        // Unshaped build: a dequeue every cycle with tokens tied low.
        to_pos();
        bus.i__refill_tokens = 8'd3;
        for (int i = 0; i < 20; i++) push(8'(i + 80), 16'(16'h600 + i));
        for (int i = 0; i < 20; i++) begin
            to_neg();
            chk("s6_deq_every", bus.o__pifo_dequeue, 1);
            chk("s6_tok_zero", bus.o__tokens, 0);
            to_pos();
        end
        to_neg();
        chk("s6_deq_done", bus.o__pifo_dequeue, 0);
        to_pos();
        drain("s6_drained", 10);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pifo_dequeue_shaper.md
PIFO_DEQUEUE_SHAPER -- requirements
Module: pifo_dequeue_shaper

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
- PRIORITY_WIDTH, 8, head priority width.
- DATA_WIDTH, 16, packet pointer width.
- TOKEN_WIDTH, 8, token counter width.
- BUCKET_MAX, 16, token saturation value (≤ 2^TOKEN_WIDTH-1).
- REFILL_PERIOD, 4, cycles between refills (≥ 1).
REQ-002 Ports SHALL be, as name, direction, width, meaning:
- clk, in, 1, single clock.
- reset, in, 1, asynchronous, active-low.
- i__pifo_empty, in, 1, upstream PIFO empty.
- i__pifo_priority, in, PRIORITY_WIDTH, upstream head priority, valid while not empty.
- i__pifo_data, in, DATA_WIDTH, upstream head packet pointer.
- o__pifo_dequeue, out, 1, pops the PIFO head at the rising clk edge.
- i__refill_tokens, in, TOKEN_WIDTH, tokens added per refill.
- o__data_out_valid, out, 1, output valid.
- o__data_out_priority, out, PRIORITY_WIDTH, output priority.
- o__data_out, out, DATA_WIDTH, output packet pointer.
- i__data_out_ready, in, 1, downstream ready.
- o__tokens, out, TOKEN_WIDTH, current token count.

Function
REQ-003 The block SHALL hold a 2-entry output buffer with states EMPTY, ONE, TWO.
REQ-004 o__pifo_dequeue SHALL be asserted exactly when all of the following hold:
- i__pifo_empty=0;
- tokens ≥ 1;
- buffer state ≠ TWO.

It SHALL be computed from registered state and i__pifo_empty only, with no combinational path from i__data_out_ready.
REQ-005 On a cycle with o__pifo_dequeue=1, {i__pifo_priority, i__pifo_data} SHALL be written to the buffer tail at the same edge. It appears at the output no earlier than the next cycle (latency 1).
REQ-006 o__data_out_valid SHALL be 1 exactly when the state is ONE or TWO. The outputs SHALL present the buffer head, in FIFO order.
REQ-007 Handshake rules:
- A transfer SHALL occur when o__data_out_valid and i__data_out_ready are both 1.
- Once valid is asserted, the output data SHALL stay stable until transferred.
- Valid SHALL not drop without a transfer.
REQ-008 State transitions:
- EMPTY→ONE on write.
- ONE→TWO on write without transfer.
- ONE→EMPTY on transfer without write.
- TWO→ONE on transfer.
- Simultaneous write and transfer in ONE SHALL remain in ONE.
- Otherwise the state holds.
REQ-009 A refill counter SHALL count 0..REFILL_PERIOD-1 and wrap. The refill event SHALL occur on the cycle the counter equals REFILL_PERIOD-1.
REQ-010 Token update SHALL be next = min(tokens − consume + refill, BUCKET_MAX), where:
- consume = o__pifo_dequeue;
- refill = i__refill_tokens on a refill event, else 0;
- arithmetic SHALL use TOKEN_WIDTH+1 bits, so there is no wrap-around.
REQ-011 With tokens=0, no dequeue SHALL occur, even on a refill cycle; the refilled tokens SHALL become usable the following cycle.
REQ-012 With i__refill_tokens=0, tokens SHALL only decrease, and dequeueing SHALL stop at 0.
REQ-013 o__tokens SHALL equal the registered token count.

Reset
REQ-014 While reset=0, asynchronously and held, the block SHALL set:
- buffer state EMPTY;
- o__data_out_valid=0, o__pifo_dequeue=0;
- o__data_out=0, o__data_out_priority=0;
- tokens=BUCKET_MAX, refill counter=0.
REQ-015 Reset asserted mid-operation SHALL discard buffered entries. Entries already popped from the PIFO are lost, and this SHALL be an accepted, documented loss.
REQ-016 The first dequeue after reset release SHALL be possible in the first cycle after the release edge.

Configuration
REQ-017 Macro PIFO_DEQUEUE_SHAPER_EN SHALL control the token bucket:
- Defined: token-bucket shaping SHALL operate per REQ-009..REQ-013.
- Undefined: the token bucket and refill counter SHALL be compiled out; the token condition in REQ-004 SHALL be treated as always true; i__refill_tokens SHALL be ignored; o__tokens SHALL be tied 0.
- Buffer behaviour SHALL be identical in both builds.

Verification
REQ-018 The bench SHALL cover these directed scenarios (defaults, macro defined unless stated):
- Reset then 3 PIFO entries (prio 5,2,9; ptr 0x11,0x22,0x33), ready=1 → dequeue on cycles 1,2,3; output 0x11,0x22,0x33 on cycles 2,3,4; o__tokens 16→13.
- Ready=0, PIFO holds 4 entries → exactly 2 dequeues, state TWO, then o__pifo_dequeue=0; output holds 0x11 stable; ready=1 → in-order drain, no loss or duplicate.
- Tokens drained to 0, refill=1, 10 entries queued, ready=1 → one dequeue per 4 cycles, each on the cycle after a refill; o__tokens alternates 0/1.
- Refill=10 with tokens=12 on a refill cycle and no dequeue → o__tokens=16 (saturated); with a dequeue the same cycle → 16.
- Reset asserted while state TWO and tokens=7 → valid=0 immediately (asynchronous), tokens=16 after release, no spurious dequeue during reset.
- Macro undefined, ready=1, 20 entries → dequeue every cycle, o__tokens=0 throughout.
